// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter command controller.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        LOAD,
        SETTLE
    } ctrl_state_e;

    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_JUMP = 1'b1;

    localparam int GAP_W = 4;

endpackage

// File: rtl/step_gap_timer.sv
// Loadable down-counter that spaces ramp steps; idles at zero.
module step_gap_timer
    import counter_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    output logic             zero
);

    logic [GAP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down counter driven by the ramp controller; load beats up beats down.
module updown_counter #(
    parameter int N = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       countup,
    input  logic       countdown,
    input  logic [N:0] d,
    output logic [N:0] q
);

    logic [N:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = d;
        else if (countup)
            q_d = q_q + 1'b1;
        else if (countdown)
            q_d = q_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/counter_ramp_ctrl.sv
// Drives a loadable up/down counter to a requested target, either by a
// single load (jump) or by paced single steps (ramp), closing the loop on q_in.
module counter_ramp_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N   = 6,
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [N:0] req_target,
    input  logic       req_mode,
    input  logic       abort,
    input  logic [N:0] q_in,
    output logic [N:0] d,
    output logic       load,
    output logic       countup,
    output logic       countdown,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP);

    ctrl_state_e state_q, state_d;
    logic [N:0]  target_q, target_d;
    logic [N:0]  d_q, d_d;
    logic        load_q, load_d;
    logic        up_q, up_d;
    logic        dn_q, dn_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        gap_clr, gap_load, gap_zero;

    step_gap_timer u_gap (
        .clk      (clk),
        .rst_n    (rst),
        .clr      (gap_clr),
        .load     (gap_load),
        .load_val (GAP_LD),
        .zero     (gap_zero)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        d_d      = d_q;
        load_d   = 1'b0;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        gap_clr  = 1'b0;
        gap_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_target;
                    if (req_mode == MODE_JUMP) begin
                        load_d  = 1'b1;
                        d_d     = req_target;
                        state_d = LOAD;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    gap_clr = 1'b1;
                    d_d     = '0;
                    state_d = IDLE;
                end else if (gap_zero) begin
                    // Unsigned compare picks the direction, so the ramp never wraps.
                    if (q_in == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (q_in < target_q) begin
                        up_d     = 1'b1;
                        gap_load = 1'b1;
                    end else begin
                        dn_d     = 1'b1;
                        gap_load = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    gap_clr = 1'b1;
                    d_d     = '0;
                    state_d = IDLE;
                end else begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    gap_clr = 1'b1;
                    d_d     = '0;
                end else begin
                    done_d = 1'b1;
                    err_d  = (q_in != target_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            d_q      <= '0;
            load_q   <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            d_q      <= d_d;
            load_q   <= load_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign d         = d_q;
    assign load      = load_q;
    assign countup   = up_q;
    assign countdown = dn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_counter_ramp_ctrl.sv
// Randomized bench: two controller+counter pairs (GAP=1 and GAP=3) checked against
// a request-level model of step counts, pulse timing, done latency and final value.
module tb_counter_ramp_ctrl;
    import counter_ctrl_pkg::*;

    localparam int N = 6;
    localparam int QMAX = (1 << (N + 1)) - 1;

    logic       clk;
    logic       rst;
    logic       rv[2];
    logic [N:0] rt[2];
    logic       rm[2];
    logic       ab[2];
    logic       fz[2];
    logic       rr[2], ld[2], cu[2], cd[2], bz[2], dn[2], er[2];
    logic [N:0] dd[2], q[2], qi[2];

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[2];

    for (genvar g = 0; g < 2; g++) begin : g_pair
        counter_ramp_ctrl #(.N(N), .GAP(g == 0 ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (rv[g]),
            .req_ready  (rr[g]),
            .req_target (rt[g]),
            .req_mode   (rm[g]),
            .abort      (ab[g]),
            .q_in       (qi[g]),
            .d          (dd[g]),
            .load       (ld[g]),
            .countup    (cu[g]),
            .countdown  (cd[g]),
            .busy       (bz[g]),
            .done       (dn[g]),
            .err        (er[g])
        );

        updown_counter #(.N(N)) u_cnt (
            .clk       (clk),
            .rst_n     (rst),
            .load      (ld[g]),
            .countup   (cu[g]),
            .countdown (cd[g]),
            .d         (dd[g]),
            .q         (q[g])
        );

        assign qi[g] = fz[g] ? '0 : q[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One request end to end; abort_at >= 0 cancels after that many step pulses.
    task automatic run_req(input int u, input int tgt, input bit jump, input bit zero_q,
                           input int abort_at, input bit hold);
        int gap = (u == 0) ? 1 : 3;
        int q0  = exp_q[u];
        int k   = (tgt > q0) ? tgt - q0 : q0 - tgt;
        int nup = 0, ndn = 0, nld = 0, multi = 0;
        int done_s = -1, err_v = -1, q_done = -1, exp_done;
        int pulses[$];
        bit aborted = 1'b0;
        logic [N:0] tgt_v;

        tgt_v    = tgt[N:0];
        exp_done = jump ? 2 : 1 + k * (gap + 1);

        @(negedge clk);
        chk("ready_idle", int'(rr[u]), 1);
        rv[u] = 1'b1;
        rt[u] = tgt_v;
        rm[u] = jump ? MODE_JUMP : MODE_RAMP;
        fz[u] = zero_q;
        @(posedge clk);
        #1;
        if (!hold) rv[u] = 1'b0;
        rt[u] = ~tgt_v;
        rm[u] = ~rm[u];

        for (int s = 0; s < exp_done + 6; s++) begin
            @(negedge clk);
            if (s == 0) begin
                chk("busy_on", int'(bz[u]), 1);
                chk("ready_busy", int'(rr[u]), 0);
            end
            if (int'(cu[u]) + int'(cd[u]) + int'(ld[u]) > 1) multi++;
            if (cu[u]) begin nup++; pulses.push_back(s); end
            if (cd[u]) begin ndn++; pulses.push_back(s); end
            if (ld[u]) begin
                nld++;
                chk("load_d", int'(dd[u]), tgt);
            end
            if (dn[u]) begin
                done_s = s;
                err_v  = int'(er[u]);
                q_done = int'(q[u]);
                break;
            end
            if (abort_at >= 0 && nup + ndn == abort_at) begin
                ab[u] = 1'b1;
                @(posedge clk);
                #1 ab[u] = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        rv[u] = 1'b0;
        fz[u] = 1'b0;
        chk("cmd_onehot", multi, 0);

        if (aborted) begin
            @(negedge clk);
            chk("abort_busy", int'(bz[u]), 0);
            chk("abort_ready", int'(rr[u]), 1);
            chk("abort_nodone", int'(dn[u]), 0);
            chk("abort_cmds", int'(cu[u]) + int'(cd[u]) + int'(ld[u]), 0);
            exp_q[u] = (tgt > q0) ? q0 + abort_at : q0 - abort_at;
            chk("abort_q", int'(q[u]), exp_q[u]);
        end else if (jump) begin
            chk("jump_loads", nld, 1);
            chk("jump_steps", nup + ndn, 0);
            chk("jump_done_t", done_s, exp_done);
            chk("jump_err", err_v, (zero_q && tgt != 0) ? 1 : 0);
            chk("jump_q", q_done, tgt);
            exp_q[u] = tgt;
        end else begin
            chk("ramp_ups", nup, (tgt > q0) ? k : 0);
            chk("ramp_downs", ndn, (tgt < q0) ? k : 0);
            chk("ramp_loads", nld, 0);
            chk("ramp_done_t", done_s, exp_done);
            chk("ramp_err", err_v, 0);
            chk("ramp_q", q_done, tgt);
            foreach (pulses[i]) chk("step_time", pulses[i], 1 + i * (gap + 1));
            exp_q[u] = tgt;
        end
    endtask

    initial begin
        int u, tgt, lo, hi;
        bit jump, zq, seen;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rt[i] = '0; rm[i] = 1'b0; ab[i] = 1'b0; fz[i] = 1'b0;
            exp_q[i] = 0;
        end
        #1 rst = 1'b0;
        #3;
        chk("rst_ready", int'(rr[0]), 1);
        chk("rst_busy", int'(bz[0]), 0);
        chk("rst_load", int'(ld[1]), 0);
        chk("rst_done", int'(dn[1]), 0);
        chk("rst_d", int'(dd[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Ramp up 5 -> 8 with GAP=1, ramp down 10 -> 7 with GAP=3.
        run_req(0, 5, 1'b1, 1'b0, -1, 1'b0);
        run_req(0, 8, 1'b0, 1'b0, -1, 1'b0);
        run_req(1, 10, 1'b1, 1'b0, -1, 1'b0);
        run_req(1, 7, 1'b0, 1'b0, -1, 1'b0);

        // Jump, then jump with the feedback forced low.
        run_req(0, 100, 1'b1, 1'b0, -1, 1'b0);
        run_req(0, 100, 1'b1, 1'b1, -1, 1'b0);

        // Already at target.
        run_req(0, 42, 1'b1, 1'b0, -1, 1'b0);
        run_req(0, 42, 1'b0, 1'b0, -1, 1'b0);

        // Full-range climb cancelled after 20 steps.
        run_req(0, 0, 1'b1, 1'b0, -1, 1'b0);
        run_req(0, QMAX, 1'b0, 1'b0, 20, 1'b0);

        // req_valid held high (with a changing target) while busy.
        run_req(1, 15, 1'b0, 1'b0, -1, 1'b1);

        // Reset in the middle of a countup pulse.
        run_req(0, 50, 1'b1, 1'b0, -1, 1'b0);
        @(negedge clk);
        rv[0] = 1'b1; rt[0] = 7'd60; rm[0] = MODE_RAMP;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        seen = 1'b0;
        for (int s = 0; s < 10 && !seen; s++) begin
            @(negedge clk);
            seen = cu[0];
        end
        chk("rst_pulse_seen", int'(seen), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_up", int'(cu[0]), 0);
        chk("rst_mid_busy", int'(bz[0]), 0);
        chk("rst_mid_ready", int'(rr[0]), 1);
        chk("rst_mid_q", int'(q[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q[0] = 0;
        exp_q[1] = 0;

        for (int it = 0; it < 40; it++) begin
            u    = int'($urandom_range(0, 1));
            jump = ($urandom_range(0, 3) == 0);
            zq   = jump && ($urandom_range(0, 3) == 0);
            if (jump) begin
                tgt = int'($urandom_range(0, QMAX));
            end else begin
                lo  = (exp_q[u] > 12) ? exp_q[u] - 12 : 0;
                hi  = (exp_q[u] + 12 < QMAX) ? exp_q[u] + 12 : QMAX;
                tgt = int'($urandom_range(hi, lo));
            end
            run_req(u, tgt, jump, zq, -1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_ramp_ctrl.md
# counter_ramp_ctrl

Command-side controller for the team's loadable up/down counter: it accepts a target-value request and drives the counter's `load`/`countup`/`countdown`/`d` inputs until the counter output equals the target. It works in one of two ways: an immediate jump (load) or a paced one-step-at-a-time ramp. It sits between a request source (register bank or test sequencer) and one counter instance, and closes the loop through the counter's `q`.

## Interface
Parameters:
- `N`, 6: counter MSB index; all count/target buses are N+1 bits.
- `GAP`, 1: idle cycles after each ramp step pulse before the next compare; legal range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where both are high.
- `req_target`  in  N+1  target count, unsigned.
- `req_mode`  in  1  0 = ramp, 1 = jump.
- `abort`  in  1  synchronous cancel of an active request.
- `q_in`  in  N+1  counter output, fed back.
- `d`  out  N+1  load value to the counter.
- `load`  out  1  one-cycle load pulse.
- `countup`  out  1  one-cycle increment pulse.
- `countdown`  out  1  one-cycle decrement pulse.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; set on a jump verify mismatch.

## Operation
- States: IDLE, RAMP, LOAD, SETTLE.
- All command outputs and `done`/`err` are registered.
- At most one of `load`/`countup`/`countdown` is high in any cycle, so the counter's internal command priority never matters.
- Reset values: state IDLE, `load`/`countup`/`countdown`/`done`/`err`/`busy` = 0, `d` = 0, gap counter = 0. `req_ready` = 1 during and after reset.
- IDLE: on accept, latch `req_target` into the target register.
  - `req_mode`=0 → RAMP with the gap counter at 0.
  - `req_mode`=1 → LOAD, with `load`=1 and `d`=target registered in the same edge.
- RAMP, each edge:
  - Gap counter ≠ 0: decrement it, no command.
  - Gap counter = 0, unsigned compare of `q_in` against target:
    - equal → `done`=1, `err`=0, go to IDLE.
    - `q_in` < target → `countup`=1 for one cycle, gap counter ← GAP.
    - `q_in` > target → `countdown`=1 for one cycle, gap counter ← GAP.
  - The ramp never wraps: direction comes from an unsigned compare, so travel from 0 to 2^(N+1)−1 is a monotonic climb.
- LOAD: next edge clears `load` and moves to SETTLE.
- SETTLE: next edge compares `q_in` to target, pulses `done`=1 with `err`=(`q_in`≠target), and goes to IDLE.
- `abort` high in RAMP/LOAD/SETTLE: next edge → IDLE, all command outputs 0, gap counter 0, no `done`. `abort` is ignored in IDLE.
- `req_valid` outside IDLE is ignored, because `req_ready`=0. `req_target` may change freely after acceptance.
- Reset asserted mid-operation: all outputs return to reset values immediately, including any in-flight command pulse.

## Timing
Edge a is the accept edge. A decision made at edge e has its pulse high in cycle e..e+1, the counter updates at e+1, and `q_in` is valid for compare at e+2. GAP ≥ 1 guarantees this.
- Ramp of k steps: compares at edges a+1+i·(GAP+1) for i = 0..k. `done` is high in the cycle after edge a+1+k·(GAP+1).
- Ramp with target already equal: `done` in the cycle after a+1.
- Jump: `load` high in cycle a..a+1, SETTLE after a+1, `done` in the cycle after a+2.
- New request acceptance: earliest on the edge following `done`.

## Structure
- Package `counter_ctrl_pkg`:
  - state enum (IDLE, RAMP, LOAD, SETTLE).
  - mode constants `MODE_RAMP`=0, `MODE_JUMP`=1.
  - gap counter width constant (4 bits).
- One sub-module, `step_gap_timer`: loadable 4-bit down-counter with `load`/`zero` interface, reset to 0. The FSM and compare stay in `counter_ramp_ctrl`.
- The bench instantiates the real counter, with its `q` tied to `q_in`.

## Test plan
- Ramp up, N=6, GAP=1, counter at 5, target 8 → exactly three `countup` pulses two cycles apart, no `countdown`, `done` with `err`=0 at edge a+7, `q`=8.
- Ramp down, counter at 10, target 7, GAP=3 → three `countdown` pulses four cycles apart, `done` at a+13, `q`=7.
- Jump, target 100, `req_mode`=1 → one `load` pulse with `d`=100, `done`/`err`=0 at a+2, `q`=100. Repeat with `q_in` forced to 0 → `err`=1.
- Target equal to current `q` (42), ramp → no command pulses, `done` at a+1.
- Ramp 0→127, abort asserted after 20 pulses → IDLE next edge, no `done`, `q`=20, `req_ready`=1.
- `rst` low during a `countup` pulse → pulse drops asynchronously, `busy`=0, `req_ready`=1. Also: a `req_valid` held high while busy is not accepted.
